// File: rtl/config_register_bank.sv
// ---------------------------------------------------------------------------
// config_register_bank
//   Double-buffered configuration register bank. Register 0 is a control
//   register whose bit 0 drives a CONFIG -> COMMIT -> OPERATE handshake.
//   Registers 1..NUM_REGS-1 each have a shadow copy (written in CONFIG) and an
//   active copy (loaded from the shadow copy in the single COMMIT cycle).
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   wen          : write request
//   waddr        : write address
//   data_in      : write data
//   ren          : read request
//   raddr        : read address
//   rdata        : registered read data, held while rvalid=0
//   rvalid       : one-cycle pulse, read data valid
//   mode         : 0 = config, 1 = operate
//   cfg_out      : active registers flattened; slice 0 is {zeros, mode}
//   commit_pulse : high for exactly the COMMIT cycle
//   wr_err       : one-cycle pulse after a rejected write
// ---------------------------------------------------------------------------
module config_register_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       ren,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic                       mode,
    output logic [NUM_REGS*DATA_W-1:0] cfg_out,
    output logic                       commit_pulse,
    output logic                       wr_err
);

    typedef enum logic [1:0] {
        ST_CONFIG  = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_OPERATE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shadow [1:NUM_REGS-1];
    logic [DATA_W-1:0]   r_active [1:NUM_REGS-1];
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_commit_pulse;
    logic                r_wr_err;

    logic                w_mode;
    logic                w_waddr_oor;
    logic                w_wr_ctrl;
    logic                w_shadow_we;
    logic                w_wr_reject;
    logic [DATA_W-1:0]   w_rd_val;

    assign w_mode      = (r_state == ST_OPERATE);
    assign w_waddr_oor = ({1'b0, waddr} >= LP_NUM_REGS);
    // Control register write: only bit 0 carries meaning.
    assign w_wr_ctrl   = wen && (waddr == '0);
    assign w_shadow_we = wen && !w_waddr_oor && (waddr != '0) && (r_state == ST_CONFIG);
    assign w_wr_reject = wen && (w_waddr_oor
                                 || (r_state == ST_COMMIT)
                                 || ((r_state == ST_OPERATE) && (waddr != '0)));

    // Next-state logic for the commit handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CONFIG:  if (w_wr_ctrl && data_in[0])  w_state_nxt = ST_COMMIT;
            ST_COMMIT:                                w_state_nxt = ST_OPERATE;
            ST_OPERATE: if (w_wr_ctrl && !data_in[0]) w_state_nxt = ST_CONFIG;
            default:                                  w_state_nxt = ST_CONFIG;
        endcase
    end

    // Read mux sees pre-edge contents, so a same-cycle write is not visible.
    always_comb begin
        w_rd_val = '0;
        if (raddr == '0) begin
            w_rd_val = {{(DATA_W-1){1'b0}}, w_mode};
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr == ADDR_W'(i)) begin
                w_rd_val = r_active[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_CONFIG;
            r_rdata        <= '0;
            r_rvalid       <= 1'b0;
            r_commit_pulse <= 1'b0;
            r_wr_err       <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_commit_pulse <= (w_state_nxt == ST_COMMIT);
            r_wr_err       <= w_wr_reject;
            r_rvalid       <= ren;
            if (ren) begin
                r_rdata <= w_rd_val;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_shadow_we && (waddr == ADDR_W'(i))) begin
                    r_shadow[i] <= data_in;
                end
                if (r_state == ST_COMMIT) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign rdata        = r_rdata;
    assign rvalid       = r_rvalid;
    assign mode         = w_mode;
    assign commit_pulse = r_commit_pulse;
    assign wr_err       = r_wr_err;

    assign cfg_out[DATA_W-1:0] = {{(DATA_W-1){1'b0}}, w_mode};
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_out[g*DATA_W +: DATA_W] = r_active[g];
    end

endmodule

// File: doc/config_register_bank.md
CONFIG_REGISTER_BANK -- requirements
Module: config_register_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits (min 2).
REQ-002 The block SHALL have parameter NUM_REGS, default 4, meaning register count including control register 0 (min 2).
REQ-003 The block SHALL have parameter ADDR_W, default 2, meaning address width, with NUM_REGS <= 2**ADDR_W.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset; it is synchronous and active-high.
REQ-006 The block SHALL have port wen  input  1  meaning write request, sampled each clk edge.
REQ-007 The block SHALL have port waddr  input  ADDR_W  meaning write address.
REQ-008 The block SHALL have port data_in  input  DATA_W  meaning write data.
REQ-009 The block SHALL have port ren  input  1  meaning read request.
REQ-010 The block SHALL have port raddr  input  ADDR_W  meaning read address.
REQ-011 The block SHALL have port rdata  output  DATA_W  meaning registered read data.
REQ-012 The block SHALL have port rvalid  output  1  meaning rdata valid, one-cycle pulse.
REQ-013 The block SHALL have port mode  output  1  meaning 0 = config, 1 = operate.
REQ-014 The block SHALL have port cfg_out  output  NUM_REGS*DATA_W  meaning active registers flattened; slice i holds register i, and slice 0 is {zeros, mode}.
REQ-015 The block SHALL have port commit_pulse  output  1  meaning high for exactly the COMMIT cycle.
REQ-016 The block SHALL have port wr_err  output  1  meaning one-cycle pulse on a rejected write.

Function
REQ-017 The block SHALL hold per register 1..NUM_REGS-1 a shadow copy and an active copy.
REQ-018 The block SHALL implement a state machine with states CONFIG, COMMIT and OPERATE.
REQ-019 In CONFIG, a write to register 1..NUM_REGS-1 SHALL update the shadow copy on the next edge, with the active copy unchanged.
REQ-020 In CONFIG, a write to register 0 with data_in[0]=1 SHALL move the state to COMMIT; with data_in[0]=0 it SHALL have no effect and no error.
REQ-021 COMMIT SHALL last exactly one cycle: all shadow copies are copied to active copies, commit_pulse=1, then the state moves to OPERATE.
REQ-022 The cfg_out active values SHALL change on the edge ending COMMIT, and mode SHALL equal 1 from that same edge.
REQ-023 In OPERATE, a write to register 1..NUM_REGS-1 SHALL be ignored and SHALL pulse wr_err on the next cycle.
REQ-024 In OPERATE, a write to register 0 with data_in[0]=0 SHALL return the state to CONFIG, with shadow and active copies retained; data_in[0]=1 SHALL have no effect and no error.
REQ-025 Any write during COMMIT SHALL be ignored and SHALL pulse wr_err.
REQ-026 A write with waddr >= NUM_REGS SHALL be ignored in every state and SHALL pulse wr_err.
REQ-027 Bits [DATA_W-1:1] of a write to register 0 SHALL be ignored.
REQ-028 A read with ren=1 SHALL produce rdata and rvalid=1 on the next cycle, giving a latency of 1.
REQ-029 A read SHALL return the active copy for addresses 1..NUM_REGS-1, {zeros, mode} for address 0, and zero for out-of-range addresses.
REQ-030 A read and a write to the same address in the same cycle SHALL return the pre-write value.
REQ-031 rdata SHALL hold its last value while rvalid=0.
REQ-032 Back-to-back reads SHALL be accepted every cycle.
REQ-033 wr_err and commit_pulse SHALL be registered outputs.

Reset
REQ-034 rst=1 at a clk edge SHALL set the state to CONFIG and clear every shadow and active copy.
REQ-035 rst=1 at a clk edge SHALL set rdata=0, rvalid=0, mode=0, cfg_out=0, commit_pulse=0 and wr_err=0.
REQ-036 Reset SHALL take priority over any simultaneous wen or ren.
REQ-037 Reset asserted during COMMIT SHALL abort the copy, leaving active copies zero and the state in CONFIG.

Verification
REQ-038 The bench SHALL cover: after reset, write reg1=0xCAFECAF0 in CONFIG -> cfg_out slice1 stays 0, and a read of reg1 returns 0 one cycle later with rvalid=1.
REQ-039 The bench SHALL cover: write reg0=0x00000001 -> commit_pulse high for one cycle, then mode=1 and slice1=0xCAFECAF0.
REQ-040 The bench SHALL cover: in OPERATE, write reg1=0xCAFECAFF -> wr_err pulses once, and a read of reg1 returns 0xCAFECAF0.
REQ-041 The bench SHALL cover: write reg0=0x00000000, write reg2=0xFACEFAC1, write reg0=0x1 -> slice2=0xFACEFAC1 and slice1=0xCAFECAF0.
REQ-042 The bench SHALL cover: write to waddr=NUM_REGS (if representable) in CONFIG -> wr_err=1 and all registers unchanged; a read of that address returns 0.
REQ-043 The bench SHALL cover: rst asserted in the COMMIT cycle -> next cycle mode=0, cfg_out=0 and commit_pulse=0.
